// File: rtl/lo_divider_pkg.sv
// Shared types and constants for the LO divider: state encoding, half-period base,
// settings-code and dwell-counter widths.
package lo_divider_pkg;

  localparam int BASE_HALF = 4;
  localparam int CODE_W    = 3;
  localparam int CNT_W     = 9;

  typedef enum logic [2:0] {
    P_HIGH  = 3'd0,
    DEAD_PN = 3'd1,
    N_HIGH  = 3'd2,
    DEAD_NP = 3'd3,
    EXT     = 3'd4
  } lo_state_e;

  // Half-period in clk cycles for divide code k: BASE_HALF << k (4..512).
  function automatic logic [CNT_W:0] half_period(input logic [CODE_W-1:0] k);
    return (CNT_W + 1)'(BASE_HALF) << k;
  endfunction

endpackage

// File: rtl/lo_divider_if.sv
// LO divider signal bundle: asynchronous control/LO inputs, registered LO outputs,
// and the FSM state exposed for debug.
interface lo_divider_if;
  import lo_divider_pkg::*;

  logic              ext_lo_en;
  logic              ext_lo_p;
  logic              ext_lo_n;
  logic [CODE_W-1:0] int_lo_settings;
  logic              lo_p;
  logic              lo_n;
  logic              lo_active;
  lo_state_e         state;

  // master drives the asynchronous inputs; slave (the divider) drives the LO outputs.
  modport master (
    output ext_lo_en, ext_lo_p, ext_lo_n, int_lo_settings,
    input  lo_p, lo_n, lo_active, state
  );

  modport slave (
    input  ext_lo_en, ext_lo_p, ext_lo_n, int_lo_settings,
    output lo_p, lo_n, lo_active, state
  );

endinterface

// File: rtl/lo_sync.sv
// Multi-flop single-bit synchronizer with asynchronous active-low reset to 0.
module lo_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/lo_divider.sv
// LO divider: divides clk into a two-phase LO with optional non-overlap gaps
// (enabled by macro LO_DIVIDER_DEADTIME_EN) and an external-LO pass-through mode.
module lo_divider
  import lo_divider_pkg::*;
#(
  parameter int DEAD_CYCLES = 1,
  parameter int SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         rst_n,
  lo_divider_if.slave bus
);

  if (DEAD_CYCLES < 1 || DEAD_CYCLES > 3 || SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_param_check
    $error("lo_divider: DEAD_CYCLES must be 1..3 and SYNC_STAGES 2..3");
  end

  logic              s_en;
  logic              s_p;
  logic              s_n;
  logic [CODE_W-1:0] s_code;

  lo_sync #(.STAGES(SYNC_STAGES)) u_sync_en (.clk(clk), .rst_n(rst_n), .d_i(bus.ext_lo_en), .q_o(s_en));
  lo_sync #(.STAGES(SYNC_STAGES)) u_sync_p  (.clk(clk), .rst_n(rst_n), .d_i(bus.ext_lo_p),  .q_o(s_p));
  lo_sync #(.STAGES(SYNC_STAGES)) u_sync_n  (.clk(clk), .rst_n(rst_n), .d_i(bus.ext_lo_n),  .q_o(s_n));

  for (genvar i = 0; i < CODE_W; i++) begin : g_code_sync
    lo_sync #(.STAGES(SYNC_STAGES)) u_sync_code (
      .clk(clk), .rst_n(rst_n), .d_i(bus.int_lo_settings[i]), .q_o(s_code[i])
    );
  end

  lo_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              lo_p_q, lo_p_d;
  logic              lo_n_q, lo_n_d;
  logic              active_q, active_d;

  logic [CNT_W:0]    half_len;
  logic [CNT_W:0]    high_len;
  logic              high_last;
  logic              take_branch;

  assign half_len = half_period(code_q);

`ifdef LO_DIVIDER_DEADTIME_EN
  logic dead_last;
  assign high_len  = half_len - (CNT_W + 1)'(DEAD_CYCLES);
  assign dead_last = (cnt_q == CNT_W'(DEAD_CYCLES - 1));
`else
  assign high_len  = half_len;
`endif

  // The counter counts up from 0 to dwell-1, so it never exceeds 511.
  assign high_last = ({1'b0, cnt_q} == (high_len - 1'b1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    code_d      = code_q;
    take_branch = 1'b0;
    case (state_q)
      P_HIGH: begin
        if (high_last) begin
          cnt_d = '0;
`ifdef LO_DIVIDER_DEADTIME_EN
          state_d = DEAD_PN;
`else
          state_d = N_HIGH;
`endif
        end
      end
      DEAD_PN: begin
`ifdef LO_DIVIDER_DEADTIME_EN
        if (dead_last) begin
          cnt_d   = '0;
          state_d = N_HIGH;
        end
`else
        cnt_d   = '0;
        state_d = N_HIGH;
`endif
      end
      N_HIGH: begin
        if (high_last) begin
          cnt_d = '0;
`ifdef LO_DIVIDER_DEADTIME_EN
          state_d = DEAD_NP;
`else
          take_branch = 1'b1;
`endif
        end
      end
      DEAD_NP: begin
`ifdef LO_DIVIDER_DEADTIME_EN
        take_branch = dead_last;
`else
        take_branch = 1'b1;
`endif
      end
      EXT: begin
        cnt_d = '0;
        if (!s_en) begin
`ifdef LO_DIVIDER_DEADTIME_EN
          state_d = DEAD_NP;
`else
          state_d = P_HIGH;
`endif
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = DEAD_NP;
      end
    endcase

    if (take_branch) begin
      cnt_d   = '0;
      state_d = s_en ? EXT : P_HIGH;
    end

    // The divide code only changes at the start of a period.
    if (state_d == P_HIGH && state_q != P_HIGH) begin
      code_d = s_code;
    end

    lo_p_d = 1'b0;
    lo_n_d = 1'b0;
    case (state_d)
      P_HIGH:  lo_p_d = 1'b1;
      N_HIGH:  lo_n_d = 1'b1;
      EXT: begin
        lo_p_d = s_p & ~s_n;
        lo_n_d = s_n & ~s_p;
      end
      default: ;
    endcase

    active_d = active_q | (state_d == P_HIGH) | (state_d == EXT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DEAD_NP;
      cnt_q    <= '0;
      code_q   <= '0;
      lo_p_q   <= 1'b0;
      lo_n_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      lo_p_q   <= lo_p_d;
      lo_n_q   <= lo_n_d;
      active_q <= active_d;
    end
  end

  assign bus.lo_p      = lo_p_q;
  assign bus.lo_n      = lo_n_q;
  assign bus.lo_active = active_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_lo_divider.sv
// Self-checking bench for lo_divider: run-length scoreboard over a divide-code table,
// a mid-period code change, asynchronous reset, and external-LO pass-through.
module tb_lo_divider;
  import lo_divider_pkg::*;

  localparam int DEAD  = 1;
  localparam int SYNC  = 2;
  localparam int RUN_W = 14;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  lo_divider_if bus();

  lo_divider #(.DEAD_CYCLES(DEAD), .SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  typedef struct {
    logic [2:0] k;
    int         half;
  } vec_t;

  vec_t              vecs[5];
  logic [RUN_W-1:0]  exp_q[$];   // {lo_p, lo_n, run length}
  int                checks   = 0;
  int                errors   = 0;
  logic              mon_en   = 1'b0;
  int                rel_edge = 0;

`ifdef LO_DIVIDER_DEADTIME_EN
  localparam lo_state_e PRE_EXT_STATE  = DEAD_NP;
  localparam lo_state_e EXT_EXIT_STATE = DEAD_NP;
  localparam logic [1:0] EXT_EXIT_PAIR = 2'b00;
  localparam logic [1:0] AFTER_P_PAIR  = 2'b00;
`else
  localparam lo_state_e PRE_EXT_STATE  = N_HIGH;
  localparam lo_state_e EXT_EXIT_STATE = P_HIGH;
  localparam logic [1:0] EXT_EXIT_PAIR = 2'b10;
  localparam logic [1:0] AFTER_P_PAIR  = 2'b01;
`endif

  // ---------------- check helpers ----------------
  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  task automatic check_pair(input string name, input logic [1:0] exp);
    checks++;
    if ({bus.lo_p, bus.lo_n} !== exp) begin
      errors++;
      $display("FAIL %s: got lo_p/lo_n=%b%b expected %b", name, bus.lo_p, bus.lo_n, exp);
    end
  endtask

  task automatic check_state(input string name, input lo_state_e exp);
    lo_state_e s;
    s = bus.state;
    checks++;
    if (s !== exp) begin
      errors++;
      $display("FAIL %s: got state %s expected %s", name, s.name(), exp.name());
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic push_run(input logic p, input logic n, input int len);
    exp_q.push_back({p, n, 12'(len)});
  endtask

  task automatic push_startup();
`ifdef LO_DIVIDER_DEADTIME_EN
    push_run(1'b0, 1'b0, DEAD);
`else
    push_run(1'b0, 1'b0, 1);
`endif
  endtask

  task automatic push_period(input int half);
`ifdef LO_DIVIDER_DEADTIME_EN
    push_run(1'b1, 1'b0, half - DEAD);
    push_run(1'b0, 1'b0, DEAD);
    push_run(1'b0, 1'b1, half - DEAD);
    push_run(1'b0, 1'b0, DEAD);
`else
    push_run(1'b1, 1'b0, half);
    push_run(1'b0, 1'b1, half);
`endif
  endtask

  // Compresses outputs into runs of constant {lo_p, lo_n} and compares each completed run.
  task automatic run_monitor();
    logic             cp, cn;
    int               len;
    logic [RUN_W-1:0] e;
    len = 0;
    forever begin
      @(negedge clk);
      checks++;
      if (bus.lo_p & bus.lo_n) begin
        errors++;
        $display("FAIL overlap: lo_p=%b lo_n=%b both high at %0t", bus.lo_p, bus.lo_n, $time);
      end
      if (!mon_en) begin
        len = 0;
      end else if (len == 0) begin
        cp  = bus.lo_p;
        cn  = bus.lo_n;
        len = 1;
      end else if (bus.lo_p === cp && bus.lo_n === cn) begin
        len++;
      end else begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL run: got unexpected run p=%b n=%b len=%0d, expected none", cp, cn, len);
        end else begin
          e = exp_q.pop_front();
          if (e !== {cp, cn, 12'(len)}) begin
            errors++;
            $display("FAIL run: got p=%b n=%b len=%0d, expected p=%b n=%b len=%0d",
                     cp, cn, len, e[13], e[12], e[11:0]);
          end
        end
        cp  = bus.lo_p;
        cn  = bus.lo_n;
        len = 1;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d runs outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic go_edge(input int target);
    while (rel_edge < target) begin
      @(posedge clk);
      rel_edge++;
    end
  endtask

  task automatic drive_at(input int target);
    go_edge(target);
    #1;
  endtask

  task automatic sample_at(input int target);
    go_edge(target);
    @(negedge clk);
  endtask

  // Asserts reset between edges, checks the asynchronous clear, releases 1 tick after a rising edge.
  task automatic do_reset(input logic [2:0] k, input logic check_p, input logic mon);
    @(posedge clk);
    #3;
    if (check_p) check_bit("pre_rst_lo_p", bus.lo_p, 1'b1);
    rst_n  = 1'b0;
    mon_en = 1'b0;
    #1;
    check_bit("rst_lo_p", bus.lo_p, 1'b0);
    check_bit("rst_lo_n", bus.lo_n, 1'b0);
    check_bit("rst_lo_active", bus.lo_active, 1'b0);
    check_state("rst_state", DEAD_NP);
    bus.ext_lo_en       = 1'b0;
    bus.ext_lo_p        = 1'b0;
    bus.ext_lo_n        = 1'b0;
    bus.int_lo_settings = k;
    repeat (3) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rel_edge = 0;
    mon_en   = mon;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{k: 3'd0, half: 4};
    vecs[1] = '{k: 3'd1, half: 8};
    vecs[2] = '{k: 3'd3, half: 32};
    vecs[3] = '{k: 3'd6, half: 256};
    vecs[4] = '{k: 3'd7, half: 512};

    bus.ext_lo_en       = 1'b0;
    bus.ext_lo_p        = 1'b0;
    bus.ext_lo_n        = 1'b0;
    bus.int_lo_settings = 3'd0;

    fork
      run_monitor();
    join_none

    // The first period after reset uses code 0: the settings synchronizer still holds its reset value.
    for (int i = 0; i < 5; i++) begin
      do_reset(vecs[i].k, i != 0, 1'b1);
      push_startup();
      push_period(4);
      push_period(vecs[i].half);
      push_period(vecs[i].half);
      drain(4 * vecs[i].half + 64);
      mon_en = 1'b0;
    end

    // Code change 2 -> 5 in the middle of a k=2 P_HIGH phase.
    do_reset(3'd2, 1'b1, 1'b1);
    push_startup();
    push_period(4);
    push_period(16);
    push_period(128);
    drive_at(14);
    bus.int_lo_settings = 3'd5;
    drain(400);
    mon_en = 1'b0;

    // External LO pass-through entry, latency, both-high masking, and exit.
    do_reset(3'd0, 1'b1, 1'b0);
    sample_at(0);
    check_bit("active_before_first_p", bus.lo_active, 1'b0);
    check_pair("release_idle", 2'b00);
    sample_at(1);
    check_bit("active_at_first_p", bus.lo_active, 1'b1);
    check_pair("first_p_high", 2'b10);
    drive_at(13);
    bus.ext_lo_en = 1'b1;
    sample_at(16);
    check_state("ext_not_early", PRE_EXT_STATE);
    sample_at(17);
    check_state("ext_entered", EXT);
    check_pair("ext_idle", 2'b00);
    drive_at(20);
    bus.ext_lo_p        = 1'b1;
    bus.int_lo_settings = 3'd1;
    sample_at(22);
    check_pair("ext_p_latency_minus1", 2'b00);
    sample_at(23);
    check_pair("ext_p_latency", 2'b10);
    drive_at(26);
    bus.ext_lo_n = 1'b1;
    sample_at(28);
    check_pair("ext_both_latency_minus1", 2'b10);
    sample_at(29);
    check_pair("ext_both_high_masked", 2'b00);
    drive_at(32);
    bus.ext_lo_p = 1'b0;
    sample_at(34);
    check_pair("ext_n_latency_minus1", 2'b00);
    sample_at(35);
    check_pair("ext_n_latency", 2'b01);
    drive_at(40);
    bus.ext_lo_en = 1'b0;
    sample_at(42);
    check_state("ext_hold", EXT);
    check_pair("ext_hold_out", 2'b01);
    sample_at(43);
    check_state("ext_exit", EXT_EXIT_STATE);
    check_pair("ext_exit_out", EXT_EXIT_PAIR);
    check_bit("active_sticky", bus.lo_active, 1'b1);
    sample_at(44);
    check_pair("post_ext_p", 2'b10);
    sample_at(50);
    check_pair("post_ext_p_last", 2'b10);
    sample_at(51);
    check_pair("post_ext_p_end", AFTER_P_PAIR);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lo_divider.md
LO_DIVIDER -- requirements
Module: lo_divider

Interface
REQ-001 SHALL have parameter DEAD_CYCLES, default 1: non-overlap gap in clk cycles; legal 1..3.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for async inputs; legal 2..3.
REQ-003 SHALL have port clk  input  1: single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port ext_lo_en  input  1: async, selects external LO pass-through.
REQ-006 SHALL have port ext_lo_p  input  1: async external LO, positive phase.
REQ-007 SHALL have port ext_lo_n  input  1: async external LO, negative phase.
REQ-008 SHALL have port int_lo_settings  input  3: async divide code k.
REQ-009 SHALL have port lo_p  output  1: registered LO to the mixer control stage, positive phase.
REQ-010 SHALL have port lo_n  output  1: registered LO to the mixer control stage, negative phase.
REQ-011 SHALL have port lo_active  output  1: registered; high while the LO is running.

Function
REQ-012 SHALL pass ext_lo_en, ext_lo_p, ext_lo_n and each int_lo_settings bit through SYNC_STAGES flops before use.
REQ-013 SHALL derive the half-period H = 4 << k clk cycles: k=0 gives 4, k=7 gives 512. The counter SHALL be 9 bits and SHALL never wrap mid-phase.
REQ-014 SHALL implement states P_HIGH, DEAD_PN, N_HIGH, DEAD_NP and EXT.
REQ-015 Transitions SHALL be: P_HIGH -> DEAD_PN -> N_HIGH -> DEAD_NP -> P_HIGH.
REQ-016 Dwell times SHALL be: P_HIGH and N_HIGH last H-DEAD_CYCLES cycles; DEAD_PN and DEAD_NP last DEAD_CYCLES cycles.
REQ-017 Output levels per state SHALL be:
- P_HIGH: lo_p=1, lo_n=0.
- N_HIGH: lo_p=0, lo_n=1.
- DEAD_PN and DEAD_NP: lo_p=0, lo_n=0.
- lo_p and lo_n SHALL never both be 1 in any cycle.
REQ-018 The synchronized settings code SHALL be latched into the active code only on entry to P_HIGH. A settings change mid-period SHALL NOT alter the current period.
REQ-019 At the DEAD_NP -> P_HIGH boundary, if synchronized ext_lo_en=1, the block SHALL go to EXT instead of P_HIGH.
REQ-020 In EXT, outputs SHALL be lo_p = sp & ~sn and lo_n = sn & ~sp, where sp and sn are the synchronized ext_lo_p and ext_lo_n. Input-to-output latency SHALL be SYNC_STAGES+1 cycles. Both inputs high SHALL give both outputs 0.
REQ-021 In EXT, when synchronized ext_lo_en=0, the block SHALL go to DEAD_NP: outputs 0 for DEAD_CYCLES cycles, then P_HIGH with a freshly latched code.
REQ-022 If ext_lo_en toggles during P_HIGH, DEAD_PN or N_HIGH, it SHALL be acted on only at the next DEAD_NP exit.
REQ-023 lo_active SHALL rise on the first entry to P_HIGH or EXT after reset and SHALL then stay 1 until reset.

Reset
REQ-024 rst_n low SHALL immediately force, asynchronously:
- lo_p=0, lo_n=0, lo_active=0;
- state=DEAD_NP, counter=0, active code=0;
- all synchronizer flops to 0.
REQ-025 After release, the block SHALL spend DEAD_CYCLES edges in DEAD_NP, then take the REQ-019 branch.
REQ-026 Reset asserted mid-phase SHALL abort the phase with no partial pulse after release.

Configuration
REQ-027 The macro LO_DIVIDER_DEADTIME_EN, when defined, SHALL select the REQ-015..REQ-017 behaviour.
REQ-028 When LO_DIVIDER_DEADTIME_EN is undefined:
- DEAD_PN and DEAD_NP SHALL be skipped; P_HIGH and N_HIGH SHALL each last H cycles.
- Outputs SHALL be complementary.
- DEAD_CYCLES SHALL be ignored.
- The boundary check of REQ-019 and the code latch SHALL occur at N_HIGH exit.
- Reset release SHALL enter the branch on the first edge.
- EXT exit SHALL go directly to P_HIGH.

Structure
REQ-029 Package lo_divider_pkg SHALL hold:
- the state enum;
- the base half-period constant 4;
- the code width 3;
- the counter width 9.
REQ-030 A sub-module lo_sync (parameterised multi-flop bit synchronizer with async reset) SHALL be instantiated once per async input bit.

Verification
REQ-031 Reset release, k=0, DEAD_CYCLES=1, macro defined: expect lo_p high 3 cycles, both low 1, lo_n high 3, both low 1; period 8 cycles; lo_active rises at the first P_HIGH.
REQ-032 k changes 2->5 mid P_HIGH: the current period stays 32 cycles; the next period is 256 cycles, starting exactly at P_HIGH entry.
REQ-033 ext_lo_en=1 asserted during N_HIGH: EXT is entered after DEAD_NP. Toggle ext_lo_p/ext_lo_n: outputs follow with 3-cycle latency; both inputs high gives both outputs 0.
REQ-034 ext_lo_en deasserted in EXT: outputs 0 for DEAD_CYCLES cycles, then P_HIGH with the current code.
REQ-035 rst_n pulled low mid P_HIGH, k=7: outputs go to 0 asynchronously; after release the sequence restarts per REQ-025.
REQ-036 Macro undefined, k=1: lo_p/lo_n are complementary, 8 cycles each. Assert lo_p&lo_n==0 in every cycle of every test.
